// File: rtl/payload_sched_pkg.sv
// Shared types for the payload engine scheduler: FSM encoding and drain counter sizing.
package payload_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStream,
    StDrain,
    StReport
  } sched_state_e;

  // Drain counter must be able to hold DRAIN_CYC itself.
  function automatic int unsigned drain_cnt_w(input int unsigned drain_cyc);
    return (drain_cyc < 1) ? 1 : $clog2(drain_cyc + 1);
  endfunction

endpackage

// File: rtl/payload_sched_stats.sv
// Packet statistics for the payload engine scheduler (built only with PAYLOAD_SCHED_STATS_EN).
// Counters advance on each result-record handshake and wrap at 2^32.
module payload_sched_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_i,
  input  logic        any_i,
  input  logic        trunc_i,
  output logic [31:0] stat_pkts_o,
  output logic [31:0] stat_hits_o,
  output logic [31:0] stat_trunc_o
);

  logic [31:0] pkts_q, hits_q, trunc_q;

  // Count records, hit records and truncated records at handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkts_q  <= '0;
      hits_q  <= '0;
      trunc_q <= '0;
    end else if (hs_i) begin
      pkts_q <= pkts_q + 32'd1;
      if (any_i)   hits_q  <= hits_q + 32'd1;
      if (trunc_i) trunc_q <= trunc_q + 32'd1;
    end
  end

  assign stat_pkts_o  = pkts_q;
  assign stat_hits_o  = hits_q;
  assign stat_trunc_o = trunc_q;

endmodule

// File: rtl/payload_engine_sched.sv
// Packet sequencer for the payload-matching engine bank: clears engines, feeds bytes on the
// shared bus, waits for the pipeline to drain and reports one record per packet.
// Optional statistics counters are added when PAYLOAD_SCHED_STATS_EN is defined.
module payload_engine_sched
  import payload_sched_pkg::*;
#(
  parameter int unsigned NUM_ENG   = 64,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_LEN   = 1500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         eng_byte,
  output logic               eng_en,
  output logic               eng_sod,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [NUM_ENG-1:0] r_match,
  output logic               r_any,
  output logic [LEN_W-1:0]   r_len,
  output logic               r_trunc
`ifdef PAYLOAD_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_trunc
`endif
);

  localparam int unsigned       CntW      = drain_cnt_w(DRAIN_CYC);
  localparam logic [CntW-1:0]   DrainLast = CntW'(DRAIN_CYC);
  localparam logic [LEN_W-1:0]  MaxLen    = LEN_W'(MAX_LEN);

  sched_state_e       state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               trunc_q, trunc_d;
  logic [7:0]         byte_q, byte_d;
  logic               en_q, en_d;
  logic               sod_q, sod_d;
  logic [NUM_ENG-1:0] r_match_q, r_match_d;
  logic               r_any_q, r_any_d;
  logic [LEN_W-1:0]   r_len_q, r_len_d;
  logic               r_trunc_q, r_trunc_d;
  logic               beat, hs;

  assign s_ready = (state_q == StStream);
  assign r_valid = (state_q == StReport);
  assign beat    = s_valid & s_ready;
  assign hs      = r_valid & r_ready;

  // Next-state and datapath updates for the packet sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    trunc_d   = trunc_q;
    byte_d    = byte_q;
    en_d      = 1'b0;
    r_match_d = r_match_q;
    r_any_d   = r_any_q;
    r_len_d   = r_len_q;
    r_trunc_d = r_trunc_q;
    unique case (state_q)
      StIdle: if (s_valid) state_d = StClr;
      StClr: begin
        len_d   = '0;
        trunc_d = 1'b0;
        state_d = StStream;
      end
      StStream: begin
        if (beat) begin
          byte_d = s_data;
          // Bytes past MAX_LEN are consumed but never reach the engines.
          if (len_q < MaxLen) en_d = 1'b1;
          else                trunc_d = 1'b1;
          if (len_q != '1) len_d = len_q + 1'b1;
          if (s_last) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d   = StReport;
          r_match_d = eng_match;
          r_any_d   = |eng_match;
          r_len_d   = len_q;
          r_trunc_d = trunc_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReport: if (hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Registered clear is high exactly while in CLR, never alongside a fed byte.
    sod_d = (state_d == StClr);
  end

  // State and output registers; reset holds the engines cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      trunc_q   <= 1'b0;
      byte_q    <= '0;
      en_q      <= 1'b0;
      sod_q     <= 1'b1;
      r_match_q <= '0;
      r_any_q   <= 1'b0;
      r_len_q   <= '0;
      r_trunc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      byte_q    <= byte_d;
      en_q      <= en_d;
      sod_q     <= sod_d;
      r_match_q <= r_match_d;
      r_any_q   <= r_any_d;
      r_len_q   <= r_len_d;
      r_trunc_q <= r_trunc_d;
    end
  end

  assign eng_byte = byte_q;
  assign eng_en   = en_q;
  assign eng_sod  = sod_q;
  assign r_match  = r_match_q;
  assign r_any    = r_any_q;
  assign r_len    = r_len_q;
  assign r_trunc  = r_trunc_q;

`ifdef PAYLOAD_SCHED_STATS_EN
  payload_sched_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_i         (hs),
    .any_i        (r_any_q),
    .trunc_i      (r_trunc_q),
    .stat_pkts_o  (stat_pkts),
    .stat_hits_o  (stat_hits),
    .stat_trunc_o (stat_trunc)
  );
`endif

endmodule

// File: tb/tb_payload_engine_sched.sv
// Bench for payload_engine_sched: a default instance and a small one (MAX_LEN=4, LEN_W=3)
// share stimulus; expectations come from per-packet arithmetic on the byte list.
module tb_payload_engine_sched;

  localparam int unsigned Drain    = 3;
  localparam int unsigned MaxLen   = 1500;
  localparam int unsigned SmallMax = 4;
  localparam int unsigned SmallSat = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] eng_match = '0;
  logic        r_ready = 1'b0;

  logic        s_ready, eng_en, eng_sod, r_valid, r_any, r_trunc;
  logic [7:0]  eng_byte;
  logic [63:0] r_match;
  logic [15:0] r_len;
  logic        s_ready_s, eng_en_s, eng_sod_s, r_valid_s, r_any_s, r_trunc_s;
  logic [7:0]  eng_byte_s;
  logic [63:0] r_match_s;
  logic [2:0]  r_len_s;
`ifdef PAYLOAD_SCHED_STATS_EN
  logic [31:0] stat_pkts, stat_hits, stat_trunc;
  logic [31:0] stat_pkts_s, stat_hits_s, stat_trunc_s;
`endif

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [7:0]  fed_q[$];
  logic [7:0]  fed_s[$];
  int          sod_en_err = 0;
  int          sod_pulses = 0;
  logic        sod_prev = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  payload_engine_sched #(
    .NUM_ENG(64), .DRAIN_CYC(Drain), .LEN_W(16), .MAX_LEN(MaxLen)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .eng_byte(eng_byte), .eng_en(eng_en), .eng_sod(eng_sod),
    .eng_match(eng_match), .r_valid(r_valid), .r_ready(r_ready), .r_match(r_match),
    .r_any(r_any), .r_len(r_len), .r_trunc(r_trunc)
`ifdef PAYLOAD_SCHED_STATS_EN
    , .stat_pkts(stat_pkts), .stat_hits(stat_hits), .stat_trunc(stat_trunc)
`endif
  );

  payload_engine_sched #(
    .NUM_ENG(64), .DRAIN_CYC(Drain), .LEN_W(3), .MAX_LEN(SmallMax)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_s), .eng_byte(eng_byte_s), .eng_en(eng_en_s), .eng_sod(eng_sod_s),
    .eng_match(eng_match), .r_valid(r_valid_s), .r_ready(r_ready), .r_match(r_match_s),
    .r_any(r_any_s), .r_len(r_len_s), .r_trunc(r_trunc_s)
`ifdef PAYLOAD_SCHED_STATS_EN
    , .stat_pkts(stat_pkts_s), .stat_hits(stat_hits_s), .stat_trunc(stat_trunc_s)
`endif
  );

  // Record every byte presented to the engines and any clear/enable overlap.
  always @(negedge clk) begin
    if (eng_en) fed_q.push_back(eng_byte);
    if (eng_en_s) fed_s.push_back(eng_byte_s);
    if ((eng_sod && eng_en) || (eng_sod_s && eng_en_s)) sod_en_err++;
    if (eng_sod && !sod_prev) sod_pulses++;
    sod_prev = eng_sod;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1);
  end

  task automatic send_pkt(input logic [7:0] d[$], input int n_send, input int gap_max,
                          output int unsigned t_last);
    int k;
    fed_q.delete();
    fed_s.delete();
    sod_pulses = 0;
    t_last = 0;
    for (int i = 0; i < n_send; i++) begin
      if (i > 0 && gap_max > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = (i == d.size() - 1);
      k = 0;
      while (!s_ready && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!s_ready) begin
        total++;
        bad++;
        $display("FAIL send_ready: s_ready=%0b want 1 at beat %0d", s_ready, i);
        break;
      end
      @(negedge clk);
      t_last = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] d[$],
                              input int unsigned t_last, input logic [63:0] m);
    int          k, n, nf, nfs, diff;
    logic [15:0] el;
    logic [2:0]  el_s;
    n = d.size();
    k = 0;
    while (!r_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!r_valid) begin
      bad++;
      $display("FAIL %s timeout: r_valid=0 want 1", name);
      return;
    end
    total++;
    if (cyc != t_last + Drain + 1) begin
      bad++;
      $display("FAIL %s latency: cycle=%0d want %0d", name, cyc, t_last + Drain + 1);
    end
    el   = (n > 65535) ? 16'hffff : 16'(n);
    el_s = (n > SmallSat) ? 3'(SmallSat) : 3'(n);
    total++;
    if (r_valid_s !== 1'b1 || r_len !== el || r_len_s !== el_s) begin
      bad++;
      $display("FAIL %s len: r_len=%0d/%0d valid_s=%0b want %0d/%0d", name, r_len, r_len_s,
               r_valid_s, el, el_s);
    end
    total++;
    if (r_trunc !== (n > MaxLen) || r_trunc_s !== (n > SmallMax)) begin
      bad++;
      $display("FAIL %s trunc: %0b/%0b want %0b/%0b", name, r_trunc, r_trunc_s,
               n > MaxLen, n > SmallMax);
    end
    total++;
    if (r_match !== m || r_match_s !== m || r_any !== (m != 0) || r_any_s !== (m != 0)) begin
      bad++;
      $display("FAIL %s match: r_match=%h any=%0b want %h any=%0b", name, r_match, r_any, m,
               m != 0);
    end
    nf  = (n > MaxLen) ? MaxLen : n;
    nfs = (n > SmallMax) ? SmallMax : n;
    diff = 0;
    if (fed_q.size() == nf && fed_s.size() == nfs) begin
      for (int i = 0; i < nf; i++) if (fed_q[i] !== d[i]) diff++;
      for (int i = 0; i < nfs; i++) if (fed_s[i] !== d[i]) diff++;
    end
    total++;
    if (fed_q.size() != nf || fed_s.size() != nfs || diff != 0) begin
      bad++;
      $display("FAIL %s fed: count=%0d/%0d wrong=%0d want %0d/%0d wrong=0", name,
               fed_q.size(), fed_s.size(), diff, nf, nfs);
    end
  endtask

  task automatic handshake(input string name);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    total++;
    if (r_valid !== 1'b0 || r_valid_s !== 1'b0) begin
      bad++;
      $display("FAIL %s release: r_valid=%0b/%0b want 0", name, r_valid, r_valid_s);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (s_ready !== 0 || eng_en !== 0 || eng_byte !== 0 || eng_sod !== 1 || r_valid !== 0 ||
        r_match !== 0 || r_any !== 0 || r_len !== 0 || r_trunc !== 0 || eng_sod_s !== 1) begin
      bad++;
      $display("FAIL reset_vals: rdy=%0b en=%0b byte=%h sod=%0b rv=%0b m=%h any=%0b len=%0d tr=%0b",
               s_ready, eng_en, eng_byte, eng_sod, r_valid, r_match, r_any, r_len, r_trunc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (eng_sod !== 0 || s_ready !== 0 || eng_sod_s !== 0) begin
      bad++;
      $display("FAIL reset_release: sod=%0b s_ready=%0b want 0 0", eng_sod, s_ready);
    end
  endtask

  task automatic test_get();
    logic [7:0]  d[$];
    int unsigned t;
    d = '{8'h2e, 8'h67, 8'h65, 8'h74, 8'h45};
    eng_match = '0;
    send_pkt(d, 5, 0, t);
    check_result("get", d, t, 64'h0);
    total++;
    if (sod_pulses != 1) begin
      bad++;
      $display("FAIL get_sod: pulses=%0d want 1", sod_pulses);
    end
    handshake("get");
  endtask

  task automatic test_single_hit();
    logic [7:0]  d[$];
    int unsigned t;
    d = '{8'ha5};
    eng_match = '0;
    send_pkt(d, 1, 0, t);
    @(negedge clk);
    @(negedge clk);
    eng_match[7] = 1'b1;
    check_result("hit1", d, t, 64'h80);
    handshake("hit1");
    eng_match = '0;
  endtask

  task automatic test_trunc();
    logic [7:0]  d[$];
    int unsigned t;
    for (int n = 6; n <= 9; n += 3) begin
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      send_pkt(d, n, 1, t);
      check_result("trunc", d, t, 64'h0);
      handshake("trunc");
    end
  endtask

  task automatic test_stall();
    logic [7:0]  d[$];
    logic [7:0]  d2[$];
    logic [63:0] m;
    int unsigned t;
    d  = '{8'h11, 8'h22, 8'h33};
    d2 = '{8'h44, 8'h55};
    m  = {$urandom, $urandom} | 64'h1;
    send_pkt(d, 3, 0, t);
    eng_match = m;
    check_result("stall", d, t, m);
    s_valid = 1'b1;
    s_data  = d2[0];
    eng_match = ~m;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (s_ready !== 0 || r_valid !== 1 || r_len !== 16'd3 || r_match !== m) begin
        bad++;
        $display("FAIL stall_hold: s_ready=%0b r_valid=%0b len=%0d m=%h want 0 1 3 %h",
                 s_ready, r_valid, r_len, r_match, m);
      end
    end
    handshake("stall");
    total++;
    if (eng_sod !== 0) begin
      bad++;
      $display("FAIL stall_sod_early: sod=%0b want 0", eng_sod);
    end
    @(negedge clk);
    total++;
    if (eng_sod !== 1) begin
      bad++;
      $display("FAIL stall_sod: sod=%0b want 1", eng_sod);
    end
    eng_match = '0;
    send_pkt(d2, 2, 0, t);
    check_result("stall_next", d2, t, 64'h0);
    handshake("stall_next");
  endtask

  task automatic test_reset_mid();
    logic [7:0]  d[$];
    logic [7:0]  d2[$];
    int unsigned t;
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) d2.push_back(8'($urandom));
    send_pkt(d, 3, 0, t);
    rst_n = 1'b0;
    #1;
    total++;
    if (r_valid !== 0 || eng_sod !== 1 || s_ready !== 0 || eng_en !== 0) begin
      bad++;
      $display("FAIL mid_reset: rv=%0b sod=%0b rdy=%0b en=%0b want 0 1 0 0", r_valid, eng_sod,
               s_ready, eng_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(d2, 4, 0, t);
    check_result("after_reset", d2, t, 64'h0);
    handshake("after_reset");
  endtask

  task automatic test_random();
    logic [7:0]  d[$];
    logic [63:0] m;
    int unsigned t;
    int          n;
    sod_en_err = 0;
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(10, 1);
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      m = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom} : 64'h0;
      eng_match = '0;
      send_pkt(d, n, 2, t);
      eng_match = m;
      check_result("random", d, t, m);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handshake("random");
    end
    eng_match = '0;
    total++;
    if (sod_en_err != 0) begin
      bad++;
      $display("FAIL sod_en_overlap: cycles=%0d want 0", sod_en_err);
    end
  endtask

`ifdef PAYLOAD_SCHED_STATS_EN
  task automatic test_stats();
    logic [7:0]  d[$];
    int unsigned t;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = '{8'h01, 8'h02};
    send_pkt(d, 2, 0, t);
    eng_match = 64'h8;
    check_result("stat_hit", d, t, 64'h8);
    handshake("stat_hit");
    eng_match = '0;
    d = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(d, 6, 0, t);
    check_result("stat_trunc", d, t, 64'h0);
    handshake("stat_trunc");
    d = '{8'h09, 8'h0a, 8'h0b};
    send_pkt(d, 3, 0, t);
    check_result("stat_clean", d, t, 64'h0);
    handshake("stat_clean");
    total++;
    if (stat_pkts_s !== 3 || stat_hits_s !== 1 || stat_trunc_s !== 1) begin
      bad++;
      $display("FAIL stats_small: pkts=%0d hits=%0d trunc=%0d want 3 1 1", stat_pkts_s,
               stat_hits_s, stat_trunc_s);
    end
    total++;
    if (stat_pkts !== 3 || stat_hits !== 1 || stat_trunc !== 0) begin
      bad++;
      $display("FAIL stats_main: pkts=%0d hits=%0d trunc=%0d want 3 1 0", stat_pkts,
               stat_hits, stat_trunc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_get();
    test_single_hit();
    test_trunc();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef PAYLOAD_SCHED_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
